// File: rtl/mmio_ram_responder_if.sv
// MMIO request (c0) and read-response (c2) bundle for mmio_ram_responder.
interface mmio_ram_responder_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              mmio_wr_valid;
  logic              mmio_rd_valid;
  logic [ADDR_W-1:0] mmio_addr;
  logic [1:0]        mmio_len;
  logic [8:0]        mmio_tid;
  logic [63:0]       mmio_wdata;
  logic              rsp_valid;
  logic [8:0]        rsp_tid;
  logic [63:0]       rsp_data;

  modport master (
    output mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_len, mmio_tid, mmio_wdata,
    input  rsp_valid, rsp_tid, rsp_data
  );

  modport slave (
    input  mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_len, mmio_tid, mmio_wdata,
    output rsp_valid, rsp_tid, rsp_data
  );
endinterface

// File: rtl/mmio_ram_responder.sv
// MMIO scratch RAM responder: preloads DFH/GUID qwords after reset, serves
// 32/64-bit host reads/writes at fixed latency, counts protocol errors.
// Optional macro MMIO_RAM_RO_PROTECT_EN: write-protect qwords 0..RO_WORDS-1.
module mmio_ram_responder #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [63:0] DFH0       = 64'h100000000028100A,
  parameter logic [63:0] DFH1       = 64'h96bf6f5fc4038fac,
  parameter logic [63:0] DFH2       = 64'h10c1bff188d14dfb,
  parameter int unsigned RO_WORDS   = 3
) (
  input  logic                  pClk,
  input  logic                  pck_cp2af_softReset_n,
  mmio_ram_responder_if.slave   bus,
  output logic                  init_done,
  output logic [15:0]           err_cnt
);

  localparam int unsigned QIDX_W = ADDR_W - 1;
  localparam int unsigned DEPTH  = 1 << QIDX_W;
  localparam int unsigned LAST   = RD_LATENCY - 1;
`ifdef MMIO_RAM_RO_PROTECT_EN
  localparam bit RO_PROTECT = 1'b1;
`else
  localparam bit RO_PROTECT = 1'b0;
`endif

  localparam logic [1:0] FMT_LO   = 2'd0;
  localparam logic [1:0] FMT_HI   = 2'd1;
  localparam logic [1:0] FMT_FULL = 2'd2;
  localparam logic [1:0] FMT_ZERO = 2'd3;

  typedef enum logic [2:0] {S_RST, S_INIT0, S_INIT1, S_INIT2, S_RUN} state_t;

  typedef struct packed {
    logic              valid;
    logic [QIDX_W-1:0] idx;
    logic [7:0]        be;
    logic [63:0]       data;
  } wr_t;

  typedef struct packed {
    logic       valid;
    logic [8:0] tid;
    logic [1:0] fmt;
  } rd_ctl_t;

  typedef struct packed {
    logic        valid;
    logic [8:0]  tid;
    logic [63:0] data;
  } rsp_t;

  state_t            state_q, state_nx;
  logic              init_wr_c, run_c, rd_ok_c;
  logic [QIDX_W-1:0] init_idx_c;
  logic [63:0]       init_data_c;
  logic [QIDX_W-1:0] rd_idx_c;
  wr_t               host_wr_c, wr_nx, wr_q;
  logic              wr_err_c, rd_acc_c, rd_err_c, err_inc_c;
  logic [1:0]        rd_fmt_c;
  logic [63:0]       wr_merge_c;
  logic [63:0]       ram_rd;
  rd_ctl_t           ctl_q [RD_LATENCY];
  rsp_t              rsp_c;
  rsp_t              dly_q [3];
  logic [63:0]       mem [DEPTH];

  assign rd_idx_c = bus.mmio_addr[ADDR_W-1:1];

  // Init FSM state register
  always_ff @(posedge pClk) begin
    if (!pck_cp2af_softReset_n) state_q <= S_RST;
    else                        state_q <= state_nx;
  end

  // Init FSM next state: one cycle per preload qword, then park in RUN
  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_RST:   state_nx = S_INIT0;
      S_INIT0: state_nx = S_INIT1;
      S_INIT1: state_nx = S_INIT2;
      S_INIT2: state_nx = S_RUN;
      S_RUN:   state_nx = S_RUN;
      default: state_nx = S_RST;
    endcase
  end

  // Init FSM outputs: preload write and per-state request acceptance
  always_comb begin
    init_wr_c   = 1'b0;
    init_idx_c  = '0;
    init_data_c = '0;
    run_c       = 1'b0;
    rd_ok_c     = 1'b1;
    case (state_q)
      S_RST:   rd_ok_c = 1'b0;
      S_INIT0: begin init_wr_c = 1'b1; init_idx_c = QIDX_W'(0); init_data_c = DFH0; end
      S_INIT1: begin init_wr_c = 1'b1; init_idx_c = QIDX_W'(1); init_data_c = DFH1; end
      S_INIT2: begin init_wr_c = 1'b1; init_idx_c = QIDX_W'(2); init_data_c = DFH2; end
      S_RUN:   run_c = 1'b1;
      default: rd_ok_c = 1'b0;
    endcase
  end

  // Host write decode: legality, protection and byte-enable generation
  always_comb begin
    host_wr_c = '0;
    wr_err_c  = 1'b0;
    if (bus.mmio_wr_valid) begin
      if (!run_c)                                          wr_err_c = 1'b1;
      else if (bus.mmio_len == 2'b01 && bus.mmio_addr[0])  wr_err_c = 1'b1;
      else if (bus.mmio_len[1])                            wr_err_c = 1'b1;
      else if (RO_PROTECT && rd_idx_c < QIDX_W'(RO_WORDS)) wr_err_c = 1'b1;
      else begin
        host_wr_c.valid = 1'b1;
        host_wr_c.idx   = rd_idx_c;
        host_wr_c.be    = bus.mmio_len[0] ? 8'hFF : (bus.mmio_addr[0] ? 8'hF0 : 8'h0F);
        host_wr_c.data  = bus.mmio_wdata;
      end
    end
  end

  // Read decode and per-cycle error event (at most one increment per cycle)
  always_comb begin
    rd_acc_c = bus.mmio_rd_valid && !bus.mmio_wr_valid && rd_ok_c;
    rd_err_c = rd_acc_c && (bus.mmio_len[1] || (bus.mmio_len == 2'b01 && bus.mmio_addr[0]));
    if (bus.mmio_len[1])      rd_fmt_c = FMT_ZERO;
    else if (bus.mmio_len[0]) rd_fmt_c = FMT_FULL;
    else if (bus.mmio_addr[0]) rd_fmt_c = FMT_HI;
    else                      rd_fmt_c = FMT_LO;
    err_inc_c = wr_err_c || rd_err_c || (bus.mmio_rd_valid && bus.mmio_wr_valid);
    wr_nx = host_wr_c;
    if (init_wr_c) begin
      wr_nx.valid = 1'b1;
      wr_nx.idx   = init_idx_c;
      wr_nx.be    = 8'hFF;
      wr_nx.data  = init_data_c;
    end
  end

  // Registered write port; commits to RAM one cycle after acceptance
  always_ff @(posedge pClk) begin
    if (!pck_cp2af_softReset_n) wr_q.valid <= 1'b0;
    else                        wr_q       <= wr_nx;
  end

  // Byte-enable merge of the pending write against current RAM contents
  always_comb begin
    wr_merge_c = mem[wr_q.idx];
    for (int b = 0; b < 8; b++) begin
      if (wr_q.be[b]) wr_merge_c[b*8 +: 8] = wr_q.data[b*8 +: 8];
    end
  end

  // RAM write; a write already in wr_q still lands if reset arrives
  always_ff @(posedge pClk) begin
    if (wr_q.valid) mem[wr_q.idx] <= wr_merge_c;
  end

  if (RD_LATENCY == 1) begin : g_lat1
    logic [63:0] rd_word_c;

    // The write in wr_q commits on the same edge this read samples the RAM, so bypass it
    always_comb begin
      rd_word_c = mem[rd_idx_c];
      if (wr_q.valid && wr_q.idx == rd_idx_c) begin
        for (int b = 0; b < 8; b++) begin
          if (wr_q.be[b]) rd_word_c[b*8 +: 8] = wr_q.data[b*8 +: 8];
        end
      end
    end

    // Single-cycle RAM read with forwarded bytes
    always_ff @(posedge pClk) begin
      ram_rd <= rd_word_c;
    end
  end else begin : g_lat2
    logic [QIDX_W-1:0] rd_idx_q;

    // Registered address then RAM read; any earlier write has committed by then
    always_ff @(posedge pClk) begin
      rd_idx_q <= rd_idx_c;
      ram_rd   <= mem[rd_idx_q];
    end
  end

  // Read control travels alongside the RAM access
  always_ff @(posedge pClk) begin
    if (!pck_cp2af_softReset_n) begin
      for (int i = 0; i < int'(RD_LATENCY); i++) ctl_q[i] <= '0;
    end else begin
      ctl_q[0].valid <= rd_acc_c;
      ctl_q[0].tid   <= bus.mmio_tid;
      ctl_q[0].fmt   <= rd_fmt_c;
      for (int i = 1; i < int'(RD_LATENCY); i++) ctl_q[i] <= ctl_q[i-1];
    end
  end

  // Select the requested half / full qword / zero for illegal lengths
  always_comb begin
    rsp_c       = '0;
    rsp_c.valid = ctl_q[LAST].valid;
    rsp_c.tid   = ctl_q[LAST].tid;
    case (ctl_q[LAST].fmt)
      FMT_LO:   rsp_c.data = {32'h0, ram_rd[31:0]};
      FMT_HI:   rsp_c.data = {32'h0, ram_rd[63:32]};
      FMT_FULL: rsp_c.data = ram_rd;
      default:  rsp_c.data = '0;
    endcase
  end

  // Fixed delay line to the response output, cleared by reset
  always_ff @(posedge pClk) begin
    if (!pck_cp2af_softReset_n) begin
      for (int i = 0; i < 3; i++) dly_q[i] <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_tid   <= '0;
      bus.rsp_data  <= '0;
    end else begin
      dly_q[0]      <= rsp_c;
      dly_q[1]      <= dly_q[0];
      dly_q[2]      <= dly_q[1];
      bus.rsp_valid <= dly_q[2].valid;
      bus.rsp_tid   <= dly_q[2].tid;
      bus.rsp_data  <= dly_q[2].data;
    end
  end

  // Status: init_done tracks RUN, err_cnt saturates at all-ones
  always_ff @(posedge pClk) begin
    if (!pck_cp2af_softReset_n) begin
      init_done <= 1'b0;
      err_cnt   <= '0;
    end else begin
      init_done <= (state_nx == S_RUN);
      if (err_inc_c && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mmio_ram_responder.sv
// Randomized scoreboard bench for mmio_ram_responder.
module tb_mmio_ram_responder;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LAT    = 1;
  localparam logic [63:0] D0 = 64'h100000000028100A;
  localparam logic [63:0] D1 = 64'h96bf6f5fc4038fac;
  localparam logic [63:0] D2 = 64'h10c1bff188d14dfb;
`ifdef MMIO_RAM_RO_PROTECT_EN
  localparam bit RO_EN = 1'b1;
`else
  localparam bit RO_EN = 1'b0;
`endif

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic        pClk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done;
  logic [15:0] err_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_rsp   = 0;
  int          cyc     = 0;
  int          err_m   = 0;
  logic [63:0] mm [int];
  exp_t        sb_q [$];
  exp_t        e;

  mmio_ram_responder_if #(.ADDR_W(ADDR_W)) bus ();

  mmio_ram_responder #(
    .ADDR_W(ADDR_W), .RD_LATENCY(LAT), .DFH0(D0), .DFH1(D1), .DFH2(D2), .RO_WORDS(3)
  ) dut (
    .pClk(pClk),
    .pck_cp2af_softReset_n(rst_n),
    .bus(bus),
    .init_done(init_done),
    .err_cnt(err_cnt)
  );

  always #5 pClk = ~pClk;
  always @(posedge pClk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Reference behaviour of one accepted cycle in RUN
  function automatic void model(bit wr, bit rd, logic [15:0] addr, logic [1:0] len,
                                logic [8:0] tid, logic [63:0] wd);
    int   q = int'(addr >> 1);
    bit   err = 0;
    exp_t x;
    if (wr) begin
      if (len == 2'b01 && addr[0]) err = 1;
      else if (len[1]) err = 1;
      else if (RO_EN && q < 3) err = 1;
      else if (len == 2'b01) mm[q] = wd;
      else if (addr[0]) mm[q][63:32] = wd[63:32];
      else mm[q][31:0] = wd[31:0];
      if (rd) err = 1;
    end else if (rd) begin
      x.tid = tid;
      x.cyc = cyc + int'(LAT) + 3;
      if (len == 2'b00) x.data = addr[0] ? {32'h0, mm[q][63:32]} : {32'h0, mm[q][31:0]};
      else if (len == 2'b01) begin
        x.data = mm[q];
        if (addr[0]) err = 1;
      end else begin
        x.data = 64'h0;
        err = 1;
      end
      sb_q.push_back(x);
    end
    if (err && err_m < 65535) err_m++;
  endfunction

  // Present one request for exactly one sampling edge
  task automatic drive(bit wr, bit rd, logic [15:0] addr, logic [1:0] len,
                       logic [8:0] tid, logic [63:0] wd);
    bus.mmio_wr_valid = wr;
    bus.mmio_rd_valid = rd;
    bus.mmio_addr     = addr;
    bus.mmio_len      = len;
    bus.mmio_tid      = tid;
    bus.mmio_wdata    = wd;
    @(posedge pClk);
    #1;
    if (rst_n) model(wr, rd, addr, len, tid, wd);
    else begin
      sb_q.delete();
      err_m = 0;
    end
  endtask

  task automatic idle(int n);
    repeat (n) drive(0, 0, 16'h0, 2'b00, 9'h0, 64'h0);
  endtask

  task automatic wait_init();
    int k = 0;
    while (init_done !== 1'b1 && k < 20) begin
      idle(1);
      k++;
    end
    check("init_done", 64'(init_done), 64'd1);
    mm[0] = D0;
    mm[1] = D1;
    mm[2] = D2;
    idle(1);
  endtask

  // Monitor: every response must match the head of the scoreboard
  always @(negedge pClk) begin
    if (bus.rsp_valid === 1'b1) begin
      n_rsp++;
      if (sb_q.size() == 0) check("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
      else begin
        e = sb_q.pop_front();
        check("rsp_tid", 64'(bus.rsp_tid), 64'(e.tid));
        check("rsp_data", bus.rsp_data, e.data);
        check("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    int          rsp_base, k, r, q;
    logic [1:0]  len;
    logic [15:0] addr;
    logic [63:0] wd;

    bus.mmio_wr_valid = 1'b0;
    bus.mmio_rd_valid = 1'b0;
    bus.mmio_addr     = '0;
    bus.mmio_len      = '0;
    bus.mmio_tid      = '0;
    bus.mmio_wdata    = '0;

    // Reset values
    idle(3);
    @(negedge pClk);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_tid", 64'(bus.rsp_tid), 64'd0);
    check("rst_rsp_data", bus.rsp_data, 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);

    // Preload readback
    rst_n = 1'b1;
    wait_init();
    drive(0, 1, 16'h0, 2'b01, 9'd1, 64'h0);
    drive(0, 1, 16'h2, 2'b01, 9'd2, 64'h0);
    drive(0, 1, 16'h4, 2'b01, 9'd3, 64'h0);
    idle(6);

    // Fill the scratch region (qwords 8..23)
    for (int i = 8; i < 24; i++) drive(1, 0, 16'(i * 2), 2'b01, 9'h0, {$urandom, $urandom});

    // 64-bit write then 32-bit half reads on the next two cycles
    drive(1, 0, 16'h10, 2'b01, 9'h0, 64'h1122334455667788);
    drive(0, 1, 16'h10, 2'b00, 9'h10, 64'h0);
    drive(0, 1, 16'h11, 2'b00, 9'h11, 64'h0);

    // Odd 32-bit write forwarded into an immediate 64-bit read
    drive(1, 0, 16'h21, 2'b00, 9'h0, 64'hDEADBEEF_DEADBEEF);
    drive(0, 1, 16'h20, 2'b01, 9'h20, 64'h0);
    idle(6);
    check("err_legal_traffic", 64'(err_cnt), 64'd0);

    // Write to the DFH qword, then read it back
    drive(1, 0, 16'h0, 2'b01, 9'h0, 64'hA5A5_5A5A_0F0F_F0F0);
    drive(0, 1, 16'h0, 2'b01, 9'h33, 64'h0);
    idle(6);
    check("err_ro_write", 64'(err_cnt), 64'(err_m));

    // Illegal traffic: len 11 read, simultaneous wr/rd, odd 64-bit write
    drive(0, 1, 16'h12, 2'b11, 9'h1FF, 64'h0);
    drive(1, 1, 16'h30, 2'b01, 9'h44, 64'h0123_4567_89AB_CDEF);
    drive(1, 0, 16'h31, 2'b01, 9'h0, 64'hFFFF_0000_FFFF_0000);
    drive(0, 1, 16'h30, 2'b01, 9'h45, 64'h0);
    idle(6);
    check("err_illegal", 64'(err_cnt), 64'(err_m));

    // Randomized mixed traffic
    for (int i = 0; i < 600; i++) begin
      r    = int'($urandom_range(0, 18));
      q    = (r < 3) ? r : r + 5;
      addr = 16'(q * 2 + int'($urandom_range(0, 1)));
      len  = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      wd   = {$urandom, $urandom};
      if (len == 2'b00) wd[63:32] = wd[31:0];
      r = int'($urandom_range(0, 99));
      if (r < 40)      drive(0, 1, addr, len, 9'($urandom), wd);
      else if (r < 75) drive(1, 0, addr, len, 9'h0, wd);
      else if (r < 80) drive(1, 1, addr, len, 9'($urandom), wd);
      else             idle(1);
    end
    idle(6);
    check("err_random", 64'(err_cnt), 64'(err_m));

    // Back-to-back reads with reset asserted while the 3rd read is in flight
    rsp_base = n_rsp;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) rst_n = 1'b0;
      drive(0, 1, 16'(16 + 2 * i), 2'b01, 9'(i + 100), 64'h0);
    end
    idle(4);
    check("rst_flight_rsp_le2", 64'(n_rsp - rsp_base <= 2), 64'd1);
    check("rst_flight_valid", 64'(bus.rsp_valid), 64'd0);
    rst_n = 1'b1;
    wait_init();
    check("err_after_reset", 64'(err_cnt), 64'd0);
    drive(0, 1, 16'h0, 2'b01, 9'h7, 64'h0);
    drive(0, 1, 16'h5, 2'b00, 9'h8, 64'h0);

    // Drain with a bounded wait
    k = 0;
    while (sb_q.size() != 0 && k < 20) begin
      idle(1);
      k++;
    end
    check("drain_empty", 64'(sb_q.size()), 64'd0);
    check("err_final", 64'(err_cnt), 64'(err_m));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
